// File: rtl/aes128_core.sv
// Iterative AES-128 encrypt/decrypt engine: key expansion into an 11-entry
// round-key store, then one cipher round per clock; result held until restarted.
module aes128_core (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         i_fStart,
   input  logic         i_fDec,
   input  logic [127:0] i_Data,
   input  logic [127:0] i_Key,
   output logic [127:0] o_Data,
   output logic         o_fDone
);

   typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, DONE} fsm_t;

   // Byte b of each table lives at bits [2047-8b -: 8].
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [2047:0] ISBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
      logic [10:0] top;
      top = 11'd2047 - {b, 3'b000};
      return inv ? ISBOX[top -: 8] : SBOX[top -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 4; i++) begin
         if (c[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [3:0] mix_coef(input int k, input logic inv);
      logic [3:0] c;
      case (k)
         0:       c = inv ? 4'he : 4'h2;
         1:       c = inv ? 4'hb : 4'h3;
         2:       c = inv ? 4'hd : 4'h1;
         default: c = inv ? 4'h9 : 4'h1;
      endcase
      return c;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      for (int i = 0; i < 16; i++)
         o[127-8*i -: 8] = sub_byte(s[127-8*i -: 8], inv);
      return o;
   endfunction

   // Row r rotates left by r (encrypt) or right by r (decrypt).
   function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      int src;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            src = inv ? 4 * ((c - r + 4) % 4) + r : 4 * ((c + r) % 4) + r;
            o[127-8*(4*c+r) -: 8] = s[127-8*src -: 8];
         end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      logic [7:0]   acc;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(s[127-8*(4*c+j) -: 8], mix_coef((j - r) & 3, inv));
            o[127-8*(4*c+r) -: 8] = acc;
         end
      return o;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      logic [7:0] v;
      case (i)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
      logic [31:0] w3;
      t = {k[23:0], k[31:24]};
      for (int i = 0; i < 4; i++)
         t[31-8*i -: 8] = sub_byte(t[31-8*i -: 8], 1'b0);
      t  = t ^ {rc, 24'h000000};
      w0 = k[127:96] ^ t;
      w1 = k[95:64]  ^ w0;
      w2 = k[63:32]  ^ w1;
      w3 = k[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   fsm_t         fsm_reg;
   logic [3:0]   cnt_reg;
   logic         dec_reg;
   logic [127:0] data_reg;
   logic [127:0] blk_reg;
   logic [127:0] rk_reg [0:10];

   logic [3:0]   prev_idx;
   logic [3:0]   rk_idx;
   logic         last_round;
   logic [127:0] rk_new;
   logic [127:0] round_out;

   always_comb begin
      prev_idx   = (cnt_reg == 4'd0) ? 4'd0 : cnt_reg - 4'd1;
      rk_idx     = dec_reg ? 4'd10 - cnt_reg : cnt_reg;
      last_round = (cnt_reg == 4'd10);
      rk_new     = key_next(rk_reg[prev_idx], rcon(cnt_reg));
      if (dec_reg) begin
         round_out = sub_bytes(shift_rows(blk_reg, 1'b1), 1'b1) ^ rk_reg[rk_idx];
         if (!last_round) round_out = mix_columns(round_out, 1'b1);
      end else begin
         round_out = shift_rows(sub_bytes(blk_reg, 1'b0), 1'b0);
         if (!last_round) round_out = mix_columns(round_out, 1'b0);
         round_out = round_out ^ rk_reg[rk_idx];
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         fsm_reg  <= IDLE;
         cnt_reg  <= 4'd0;
         dec_reg  <= 1'b0;
         data_reg <= '0;
         blk_reg  <= '0;
         o_Data   <= '0;
         o_fDone  <= 1'b0;
         for (int i = 0; i < 11; i++) rk_reg[i] <= '0;
      end else begin
         case (fsm_reg)
            IDLE, DONE: begin
               if (i_fStart) begin
                  data_reg  <= i_Data;
                  dec_reg   <= i_fDec;
                  rk_reg[0] <= i_Key;
                  o_fDone   <= 1'b0;
                  cnt_reg   <= 4'd1;
                  fsm_reg   <= KEYEXP;
               end
            end
            KEYEXP: begin
               rk_reg[cnt_reg] <= rk_new;
               if (cnt_reg == 4'd10) begin
                  cnt_reg <= 4'd1;
                  fsm_reg <= INIT;
               end else begin
                  cnt_reg <= cnt_reg + 4'd1;
               end
            end
            INIT: begin
               blk_reg <= data_reg ^ (dec_reg ? rk_reg[10] : rk_reg[0]);
               fsm_reg <= ROUND;
            end
            ROUND: begin
               blk_reg <= round_out;
               if (last_round) begin
                  o_Data  <= round_out;
                  o_fDone <= 1'b1;
                  cnt_reg <= 4'd0;
                  fsm_reg <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 4'd1;
               end
            end
            default: fsm_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_core.sv
// Directed-vector bench for aes128_core: known-answer table plus sequences for
// ignored starts, mid-run reset, long DONE hold, back-to-back held start.
module tb_aes128_core;

   logic         Clk = 1'b0;
   logic         Rst = 1'b0;
   logic         i_fStart = 1'b0;
   logic         i_fDec = 1'b0;
   logic [127:0] i_Data = '0;
   logic [127:0] i_Key = '0;
   logic [127:0] o_Data;
   logic         o_fDone;

   int n_cmp  = 0;
   int n_fail = 0;

   aes128_core dut (
      .Clk(Clk), .Rst(Rst), .i_fStart(i_fStart), .i_fDec(i_fDec),
      .i_Data(i_Data), .i_Key(i_Key), .o_Data(o_Data), .o_fDone(o_fDone)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      string        name;
      logic         dec;
      logic [127:0] key;
      logic [127:0] data;
      logic [127:0] expect_out;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Drive a one-cycle start; returns at the negedge after the start edge E0.
   task automatic start_op(input vec_t v, input logic hold);
      @(negedge Clk);
      i_fDec = v.dec; i_Key = v.key; i_Data = v.data; i_fStart = 1'b1;
      @(posedge Clk); #1;
      check({v.name, "_done_clear"}, {127'd0, o_fDone}, 128'd0);
      @(negedge Clk);
      if (!hold) i_fStart = 1'b0;
      i_Data = ~v.data; i_Key = ~v.key; i_fDec = ~v.dec;
   endtask

   // Count edges until o_fDone, expecting exactly `lat` more edges.
   task automatic wait_done(input vec_t v, input int lat);
      int n;
      n = 0;
      while (!o_fDone && n < 40) begin
         @(posedge Clk); #1;
         n++;
      end
      check({v.name, "_latency"}, 128'(n), 128'(lat));
      check({v.name, "_data"}, o_Data, v.expect_out);
      $display("op %s dec=%0d: result %h after %0d edges", v.name, v.dec, o_Data, n);
   endtask

   initial begin
      vec_t other;
      vecs[0] = '{"kat_enc",  1'b0, 128'h5468617473206D79204B756E67204675,
                  128'h54776F204F6E65204E696E652054776F, 128'h29C3505F571420F6402299B31A02D73A};
      vecs[1] = '{"kat_dec",  1'b1, 128'h5468617473206D79204B756E67204675,
                  128'h29C3505F571420F6402299B31A02D73A, 128'h54776F204F6E65204E696E652054776F};
      vecs[2] = '{"fips_enc", 1'b0, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      vecs[3] = '{"fips_dec", 1'b1, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
      other   = '{"other", 1'b1, 128'hffeeddccbbaa99887766554433221100,
                  128'h0123456789abcdef0123456789abcdef, 128'h0};

      repeat (3) @(posedge Clk);
      #1;
      check("reset_data", o_Data, 128'd0);
      check("reset_done", {127'd0, o_fDone}, 128'd0);
      @(negedge Clk);
      Rst = 1'b1;

      // Known-answer vectors
      for (int i = 0; i < 4; i++) begin
         start_op(vecs[i], 1'b0);
         wait_done(vecs[i], 21);
      end

      // Start during ROUND with other data/key is ignored
      start_op(vecs[0], 1'b0);
      repeat (13) @(posedge Clk);
      @(negedge Clk);
      i_fDec = other.dec; i_Key = other.key; i_Data = other.data; i_fStart = 1'b1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      i_fStart = 1'b0;
      wait_done(vecs[0], 6);

      // Reset mid-run clears outputs at once and suppresses the result
      start_op(vecs[2], 1'b0);
      repeat (8) @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      #1;
      check("midrst_data", o_Data, 128'd0);
      check("midrst_done", {127'd0, o_fDone}, 128'd0);
      @(negedge Clk);
      Rst = 1'b1;
      begin
         logic seen;
         seen = 1'b0;
         repeat (30) begin
            @(posedge Clk); #1;
            if (o_fDone) seen = 1'b1;
         end
         check("midrst_no_done", {127'd0, seen}, 128'd0);
      end
      start_op(vecs[2], 1'b0);
      wait_done(vecs[2], 21);

      // DONE holds for 60 idle cycles
      begin
         int bad;
         bad = 0;
         repeat (60) begin
            @(posedge Clk); #1;
            if (o_fDone !== 1'b1 || o_Data !== vecs[2].expect_out) bad++;
         end
         check("hold60_unstable_cycles", 128'(bad), 128'd0);
      end
      start_op(vecs[3], 1'b0);
      wait_done(vecs[3], 21);

      // Start held high: done pulses one cycle, then a second op runs
      @(negedge Clk);
      i_fDec = vecs[1].dec; i_Key = vecs[1].key; i_Data = vecs[1].data; i_fStart = 1'b1;
      @(posedge Clk); #1;
      check("held_done_clear", {127'd0, o_fDone}, 128'd0);
      wait_done(vecs[1], 21);
      @(posedge Clk); #1;
      check("held_restart_done_drop", {127'd0, o_fDone}, 128'd0);
      @(negedge Clk);
      i_fStart = 1'b0;
      wait_done(vecs[1], 21);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
